// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/execute states for the
// shared-memory single-ALU datapath, with a ready/valid memory handshake, a
// parametrised mult/div stall and illegal-opcode flagging.
module multicycle_control #(
    parameter int          MULDIV_CYCLES = 4,
    parameter logic [5:0]  SHIFT_OPCODE  = 6'b110000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       hilo_write,
    output logic       busy,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int CW = $clog2(MULDIV_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        MULDIV    = 4'd11
    } state_t;

    state_t        cur_state, next_state;
    logic [CW-1:0] cnt;
    logic          is_muldiv;

    assign is_muldiv = (funct == FN_MULT) || (funct == FN_DIV);

    // State register and mult/div stall counter (loaded on DECODE->MULDIV).
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            cnt       <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == DECODE && next_state == MULDIV)
                cnt <= CW'(MULDIV_CYCLES - 1);
            else if (cur_state == MULDIV && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    // Next-state and Moore outputs; reset overrides everything to defaults.
    always_comb begin
        next_state    = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b10;
        pc_source     = 2'b00;
        hilo_write    = 1'b0;
        busy          = 1'b0;
        illegal       = 1'b0;
        state         = cur_state;

        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b00;
                if (opcode == OP_RTYPE)
                    next_state = is_muldiv ? MULDIV : EXEC_R;
                else if (opcode == SHIFT_OPCODE)
                    next_state = EXEC_R;
                else if (opcode == OP_ADDI || opcode == OP_ANDI)
                    next_state = EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)
                    next_state = MEM_ADDR;
                else if (opcode == OP_BEQ)
                    next_state = BRANCH;
                else if (opcode == OP_J)
                    next_state = JUMP;
                else begin
                    next_state = FETCH;
                    illegal    = 1'b1;
                end
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = (opcode == SHIFT_OPCODE) ? 2'b10 : 2'b00;
                next_state = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
                next_state = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE) || (opcode == SHIFT_OPCODE);
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = FETCH;
            end
            MULDIV: begin
                alu_src_a = 1'b1;
                busy      = 1'b1;
                if (cnt == '0) begin
                    hilo_write = 1'b1;
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase

        if (reset) begin
            next_state    = FETCH;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b10;
            pc_source     = 2'b00;
            hilo_write    = 1'b0;
            busy          = 1'b0;
            illegal       = 1'b0;
            state         = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues per-cycle
// stimulus together with the expected outputs, then drains the queue one
// clock at a time comparing the full output vector.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, irw, iord, mr, mw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       hilo, busy, ill;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] fn;
        obs_t       exp;
    } ent_t;

    localparam logic [5:0] MULT = 6'b011000;
    localparam logic [5:0] DIV  = 6'b011010;

    logic       clk = 1'b0;
    logic       reset = 1'b1, reset1 = 1'b1;
    logic [5:0] opcode = 6'd0, funct = MULT;
    logic       mem_ready = 1'b0;

    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, hilo_write, busy, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    logic       pc_write1, pc_write_cond1, ir_write1, i_or_d1, mem_read1, mem_write1;
    logic       mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, hilo_write1, busy1, illegal1;
    logic [1:0] alu_src_b1, alu_op1, pc_source1;
    logic [3:0] state1;

    obs_t obs0, obs1;
    ent_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MULDIV_CYCLES(4), .SHIFT_OPCODE(6'b110000)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .hilo_write(hilo_write), .busy(busy),
        .illegal(illegal), .state(state)
    );

    multicycle_control #(.MULDIV_CYCLES(1), .SHIFT_OPCODE(6'b110000)) dut1 (
        .clk(clk), .reset(reset1), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write1), .pc_write_cond(pc_write_cond1), .ir_write(ir_write1),
        .i_or_d(i_or_d1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .reg_write(reg_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
        .pc_source(pc_source1), .hilo_write(hilo_write1), .busy(busy1),
        .illegal(illegal1), .state(state1)
    );

    assign obs0 = {state, pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, hilo_write, busy, illegal};
    assign obs1 = {state1, pc_write1, pc_write_cond1, ir_write1, i_or_d1, mem_read1,
                   mem_write1, mem_to_reg1, reg_dst1, reg_write1, alu_src_a1,
                   alu_src_b1, alu_op1, pc_source1, hilo_write1, busy1, illegal1};

    // Expected output vectors per state, written from the control table.
    function automatic obs_t e_def(input logic [3:0] st);
        obs_t e = '0;
        e.aop = 2'b10;
        e.st  = st;
        return e;
    endfunction
    function automatic obs_t e_fetch(input logic rdy);
        obs_t e = e_def(4'd0);
        e.mr = 1'b1; e.asb = 2'b01; e.aop = 2'b00; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction
    function automatic obs_t e_decode(input logic ill);
        obs_t e = e_def(4'd1);
        e.asb = 2'b11; e.aop = 2'b00; e.ill = ill;
        return e;
    endfunction
    function automatic obs_t e_maddr();
        obs_t e = e_def(4'd2);
        e.asa = 1'b1; e.asb = 2'b10; e.aop = 2'b00;
        return e;
    endfunction
    function automatic obs_t e_mread();
        obs_t e = e_def(4'd3);
        e.mr = 1'b1; e.iord = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_mwb();
        obs_t e = e_def(4'd4);
        e.rw = 1'b1; e.m2r = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_mwrite();
        obs_t e = e_def(4'd5);
        e.mw = 1'b1; e.iord = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_execr(input logic sh);
        obs_t e = e_def(4'd6);
        e.asa = 1'b1; e.asb = sh ? 2'b10 : 2'b00;
        return e;
    endfunction
    function automatic obs_t e_execi(input logic andi);
        obs_t e = e_def(4'd7);
        e.asa = 1'b1; e.asb = 2'b10; e.aop = andi ? 2'b11 : 2'b00;
        return e;
    endfunction
    function automatic obs_t e_aluwb(input logic rd);
        obs_t e = e_def(4'd8);
        e.rw = 1'b1; e.rdst = rd;
        return e;
    endfunction
    function automatic obs_t e_branch();
        obs_t e = e_def(4'd9);
        e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.psrc = 2'b01;
        return e;
    endfunction
    function automatic obs_t e_jump();
        obs_t e = e_def(4'd10);
        e.pcw = 1'b1; e.psrc = 2'b10;
        return e;
    endfunction
    function automatic obs_t e_muldiv(input logic hl);
        obs_t e = e_def(4'd11);
        e.asa = 1'b1; e.busy = 1'b1; e.hilo = hl;
        return e;
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic [5:0] op,
                        input logic [5:0] fn, input obs_t exp);
        ent_t e;
        e.rst = rst; e.rdy = rdy; e.op = op; e.fn = fn; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'd0, MULT, e_fetch(1));
        push(0, 0, 6'd0, MULT, e_decode(0));
        push(0, 1, 6'd0, MULT, e_muldiv(0));
        push(0, 0, 6'd0, MULT, e_muldiv(0));
        push(1, 1, 6'd0, MULT, e_def(4'd0));
        push(1, 0, 6'd0, MULT, e_def(4'd0));
        push(0, 0, 6'd0, MULT, e_fetch(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs0 !== e.exp) begin
                miscompares++;
                $display("FAIL reset step %0d: got %h required %h", n, obs0, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_muldiv();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'd0, MULT, e_fetch(1));
        push(0, 1, 6'd0, MULT, e_decode(0));
        push(0, 1, 6'd0, MULT, e_muldiv(0));
        push(0, 0, 6'd0, MULT, e_muldiv(0));
        push(0, 1, 6'd0, MULT, e_muldiv(0));
        push(0, 0, 6'd0, MULT, e_muldiv(1));
        push(0, 1, 6'd0, DIV,  e_fetch(1));
        push(0, 0, 6'd0, DIV,  e_decode(0));
        push(0, 0, 6'd0, DIV,  e_muldiv(0));
        push(0, 0, 6'd0, DIV,  e_muldiv(0));
        push(0, 0, 6'd0, DIV,  e_muldiv(0));
        push(0, 0, 6'd0, DIV,  e_muldiv(1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs0 !== e.exp) begin
                miscompares++;
                $display("FAIL muldiv4 step %0d: got %h required %h", n, obs0, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_lw();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'b100011, 6'd0, e_fetch(1));
        push(0, 1, 6'b100011, 6'd0, e_decode(0));
        push(0, 0, 6'b100011, 6'd0, e_maddr());
        push(0, 1, 6'b100011, 6'd0, e_mread());
        push(0, 1, 6'b100011, 6'd0, e_mwb());
        push(0, 0, 6'b100011, 6'd0, e_fetch(0));
        push(0, 1, 6'b100011, 6'd0, e_fetch(1));
        push(0, 0, 6'b100011, 6'd0, e_decode(0));
        push(0, 1, 6'b100011, 6'd0, e_maddr());
        push(0, 0, 6'b100011, 6'd0, e_mread());
        push(0, 1, 6'b100011, 6'd0, e_mread());
        push(0, 0, 6'b100011, 6'd0, e_mwb());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs0 !== e.exp) begin
                miscompares++;
                $display("FAIL lw step %0d: got %h required %h", n, obs0, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_sw();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'b101011, 6'd0, e_fetch(1));
        push(0, 0, 6'b101011, 6'd0, e_decode(0));
        push(0, 1, 6'b101011, 6'd0, e_maddr());
        push(0, 0, 6'b101011, 6'd0, e_mwrite());
        push(0, 0, 6'b101011, 6'd0, e_mwrite());
        push(0, 1, 6'b101011, 6'd0, e_mwrite());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs0 !== e.exp) begin
                miscompares++;
                $display("FAIL sw step %0d: got %h required %h", n, obs0, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_alu();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'b000000, 6'b100000, e_fetch(1));
        push(0, 1, 6'b000000, 6'b100000, e_decode(0));
        push(0, 1, 6'b000000, 6'b100000, e_execr(0));
        push(0, 1, 6'b000000, 6'b100000, e_aluwb(1));
        push(0, 1, 6'b110000, 6'b000000, e_fetch(1));
        push(0, 0, 6'b110000, 6'b000000, e_decode(0));
        push(0, 0, 6'b110000, 6'b000000, e_execr(1));
        push(0, 0, 6'b110000, 6'b000000, e_aluwb(1));
        push(0, 1, 6'b001000, 6'b011000, e_fetch(1));
        push(0, 0, 6'b001000, 6'b011000, e_decode(0));
        push(0, 0, 6'b001000, 6'b011000, e_execi(0));
        push(0, 0, 6'b001000, 6'b011000, e_aluwb(0));
        push(0, 1, 6'b001100, 6'b000000, e_fetch(1));
        push(0, 0, 6'b001100, 6'b000000, e_decode(0));
        push(0, 0, 6'b001100, 6'b000000, e_execi(1));
        push(0, 0, 6'b001100, 6'b000000, e_aluwb(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs0 !== e.exp) begin
                miscompares++;
                $display("FAIL alu step %0d: got %h required %h", n, obs0, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_branch_jump_illegal();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'b000100, 6'd0, e_fetch(1));
        push(0, 1, 6'b000100, 6'd0, e_decode(0));
        push(0, 1, 6'b000100, 6'd0, e_branch());
        push(0, 1, 6'b000010, 6'd0, e_fetch(1));
        push(0, 1, 6'b000010, 6'd0, e_decode(0));
        push(0, 1, 6'b000010, 6'd0, e_jump());
        push(0, 1, 6'b111111, 6'd0, e_fetch(1));
        push(0, 1, 6'b111111, 6'd0, e_decode(1));
        push(0, 1, 6'b000011, 6'd0, e_fetch(1));
        push(0, 0, 6'b000011, 6'd0, e_decode(1));
        push(0, 0, 6'b000011, 6'd0, e_fetch(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs0 !== e.exp) begin
                miscompares++;
                $display("FAIL br_j_ill step %0d: got %h required %h", n, obs0, e.exp);
            end
            n++;
        end
    endtask

    // Single-cycle mult/div variant; the default-parameter instance is parked in reset.
    task automatic test_muldiv1();
        ent_t e;
        int   n = 0;
        push(0, 1, 6'd0, MULT, e_fetch(1));
        push(0, 0, 6'd0, MULT, e_decode(0));
        push(0, 1, 6'd0, MULT, e_muldiv(1));
        push(0, 1, 6'd0, DIV,  e_fetch(1));
        push(0, 0, 6'd0, DIV,  e_decode(0));
        push(0, 0, 6'd0, DIV,  e_muldiv(1));
        push(0, 0, 6'd0, DIV,  e_fetch(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = 1'b1; reset1 = e.rst; mem_ready = e.rdy; opcode = e.op; funct = e.fn;
            @(negedge clk);
            vectors++;
            if (obs1 !== e.exp) begin
                miscompares++;
                $display("FAIL muldiv1 step %0d: got %h required %h", n, obs1, e.exp);
            end
            n++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_muldiv();
        test_lw();
        test_sw();
        test_alu();
        test_branch_jump_illegal();
        test_muldiv1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
